// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_pkg
//  Brief    : Shared widths, tag-entry field positions and FSM encoding for
//             the data-cache controller.
//  Revision : 1.0 - initial release
// ============================================================================
package dcache_pkg;

   localparam int TAG_W       = 23;   // addr[31:9]
   localparam int IDX_W       = 4;    // addr[8:5]
   localparam int OFF_W       = 5;    // addr[4:0]
   localparam int LINE_W      = 256;
   localparam int WORD_W      = 32;
   localparam int WSEL_W      = 3;    // word select addr[4:2]
   localparam int TAG_ENTRY_W = TAG_W + 2;

   // Tag entry layout {valid, dirty, tag}
   localparam int VALID = 24;
   localparam int DIRTY = 23;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      MISS       = 3'd1,
      WRITEBACK  = 3'd2,
      READMISS   = 3'd3,
      READMISSOK = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/dcache_controller_if.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_controller_if
//  Brief    : CPU, off-chip memory and SRAM buses of the data-cache
//             controller. master = controller side, slave = environment.
//  Revision : 1.0 - initial release
// ============================================================================
interface dcache_controller_if;
   import dcache_pkg::*;

   // CPU MEM stage
   logic [31:0]            cpu_addr_i;
   logic [WORD_W-1:0]      cpu_data_i;
   logic                   cpu_MemRead_i;
   logic                   cpu_MemWrite_i;
   logic [WORD_W-1:0]      cpu_data_o;
   logic                   cpu_stall_o;
   // Off-chip data memory
   logic [LINE_W-1:0]      mem_data_i;
   logic                   mem_ack_i;
   logic [LINE_W-1:0]      mem_data_o;
   logic [31:0]            mem_addr_o;
   logic                   mem_enable_o;
   logic                   mem_write_o;
   // dcache_sram
   logic [IDX_W-1:0]       sram_idx_o;
   logic [TAG_ENTRY_W-1:0] sram_tag_o;
   logic [LINE_W-1:0]      sram_data_o;
   logic                   sram_enable_o;
   logic                   sram_write_o;
   logic [TAG_ENTRY_W-1:0] sram_tag_i;
   logic [LINE_W-1:0]      sram_data_i;
   logic                   sram_hit_i;

   modport master (
      input  cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
      output cpu_data_o, cpu_stall_o,
      input  mem_data_i, mem_ack_i,
      output mem_data_o, mem_addr_o, mem_enable_o, mem_write_o,
      output sram_idx_o, sram_tag_o, sram_data_o, sram_enable_o, sram_write_o,
      input  sram_tag_i, sram_data_i, sram_hit_i
   );

   modport slave (
      output cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
      input  cpu_data_o, cpu_stall_o,
      output mem_data_i, mem_ack_i,
      input  mem_data_o, mem_addr_o, mem_enable_o, mem_write_o,
      input  sram_idx_o, sram_tag_o, sram_data_o, sram_enable_o, sram_write_o,
      output sram_tag_i, sram_data_i, sram_hit_i
   );

endinterface
`default_nettype wire

// File: rtl/dcache_word_merge.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_word_merge
//  Brief    : Selects one 32-bit word out of a cache line (load path) and
//             builds the line with that word replaced (store path).
//  Revision : 1.0 - initial release
// ============================================================================
module dcache_word_merge
   import dcache_pkg::*;
(
   input  logic [LINE_W-1:0] i_line,
   input  logic [WSEL_W-1:0] i_word_sel,
   input  logic [WORD_W-1:0] i_word,
   output logic [WORD_W-1:0] o_word,
   output logic [LINE_W-1:0] o_line
);

   // Bit offset of the selected word is word_sel * 32
   assign o_word = i_line[{i_word_sel, 5'b00000} +: WORD_W];

   for (genvar w = 0; w < LINE_W / WORD_W; w++) begin : g_word
      assign o_line[w*WORD_W +: WORD_W] = (i_word_sel == WSEL_W'(w)) ? i_word
                                                                   : i_line[w*WORD_W +: WORD_W];
   end

endmodule
`default_nettype wire

// File: rtl/dcache_controller.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_controller
//  Brief    : Data-cache controller for a 2-way, 16-set, 256-bit-line cache.
//             Serves hits in one cycle, stalls the CPU on a miss, writes back
//             a dirty victim and refills the line from off-chip memory.
//  Revision : 1.0 - initial release
// ============================================================================
module dcache_controller
   import dcache_pkg::*;
(
   input  logic                clk_i,
   input  logic                rst_i,
   dcache_controller_if.master bus
);

   logic                   w_req;
   logic                   w_store;
   logic                   w_miss;
   logic [TAG_W-1:0]       w_tag;
   logic [IDX_W-1:0]       w_idx;
   logic [WSEL_W-1:0]      w_word_sel;
   logic [WORD_W-1:0]      w_hit_word;
   logic [LINE_W-1:0]      w_merged_line;
   logic                   w_unused;

   state_t                 r_state;
   state_t                 w_next_state;
   logic [TAG_ENTRY_W-1:0] r_victim_tag;
   logic [LINE_W-1:0]      r_victim_line;
   logic [LINE_W-1:0]      r_refill;

   // Read+write together behaves as a store
   assign w_req      = bus.cpu_MemRead_i | bus.cpu_MemWrite_i;
   assign w_store    = bus.cpu_MemWrite_i;
   assign w_miss     = w_req & ~bus.sram_hit_i;
   assign w_tag      = bus.cpu_addr_i[31:OFF_W+IDX_W];
   assign w_idx      = bus.cpu_addr_i[OFF_W+IDX_W-1:OFF_W];
   assign w_word_sel = bus.cpu_addr_i[OFF_W-1:2];
   assign w_unused   = &{1'b0, bus.cpu_addr_i[1:0]};

   assign bus.sram_idx_o    = w_idx;
   assign bus.sram_enable_o = w_req | (r_state == READMISSOK);
   // Hit never asserts until the refilled line is in the SRAM, so this stays
   // high for the whole miss sequence
   assign bus.cpu_stall_o   = w_miss;

   dcache_word_merge u_word_merge (
      .i_line     (bus.sram_data_i),
      .i_word_sel (w_word_sel),
      .i_word     (bus.cpu_data_i),
      .o_word     (w_hit_word),
      .o_line     (w_merged_line)
   );

   // State register; reset aborts any miss in flight
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= IDLE;
      else       r_state <= w_next_state;
   end

   // Capture the LRU victim on miss entry and the refill line on read ack
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_victim_tag  <= '0;
         r_victim_line <= '0;
         r_refill      <= '0;
      end else begin
         if (r_state == IDLE && w_miss) begin
            r_victim_tag  <= bus.sram_tag_i;
            r_victim_line <= bus.sram_data_i;
         end
         if (r_state == READMISS && bus.mem_ack_i) begin
            r_refill <= bus.mem_data_i;
         end
      end
   end

   // Next-state logic plus memory, SRAM and load-data outputs
   always_comb begin
      w_next_state     = r_state;
      bus.mem_enable_o = 1'b0;
      bus.mem_write_o  = 1'b0;
      bus.mem_addr_o   = '0;
      bus.mem_data_o   = '0;
      bus.sram_write_o = 1'b0;
      bus.sram_tag_o   = '0;
      bus.sram_data_o  = '0;
      bus.cpu_data_o   = '0;
      case (r_state)
         IDLE: begin
            if (w_miss) begin
               w_next_state = MISS;
            end else if (w_req && !rst_i) begin
               if (w_store) begin
                  bus.sram_write_o = 1'b1;
                  bus.sram_tag_o   = {1'b1, 1'b1, w_tag};
                  bus.sram_data_o  = w_merged_line;
               end else begin
                  bus.cpu_data_o   = w_hit_word;
               end
            end
         end
         MISS: begin
            w_next_state = (r_victim_tag[VALID] && r_victim_tag[DIRTY]) ? WRITEBACK : READMISS;
         end
         WRITEBACK: begin
            bus.mem_enable_o = 1'b1;
            bus.mem_write_o  = 1'b1;
            bus.mem_addr_o   = {r_victim_tag[TAG_W-1:0], w_idx, {OFF_W{1'b0}}};
            bus.mem_data_o   = r_victim_line;
            if (bus.mem_ack_i) w_next_state = READMISS;
         end
         READMISS: begin
            bus.mem_enable_o = 1'b1;
            bus.mem_addr_o   = {w_tag, w_idx, {OFF_W{1'b0}}};
            if (bus.mem_ack_i) w_next_state = READMISSOK;
         end
         READMISSOK: begin
            bus.sram_write_o = 1'b1;
            bus.sram_tag_o   = {1'b1, 1'b0, w_tag};
            bus.sram_data_o  = r_refill;
            w_next_state     = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_dcache_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dcache_controller
//  Brief    : Self-checking bench: 2-way LRU SRAM model, off-chip memory
//             responder with programmable ack delay, scoreboard queues for
//             load data and memory transactions.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_controller;

   typedef struct packed {
      logic         wr;
      logic [31:0]  addr;
      logic [255:0] data;
   } memtx_t;

   logic clk_i    = 1'b0;
   logic rst_i    = 1'b1;
   logic sram_clr = 1'b1;
   always #5 clk_i = ~clk_i;

   int n_checks    = 0;
   int n_fail      = 0;
   int mem_delay   = 0;
   int tx_cnt      = 0;
   int sram_wr_cnt = 0;

   logic [255:0] mem_arr [0:255];
   logic [31:0]  gold    [0:2047];
   logic [24:0]  tag_arr [0:15][0:1];
   logic [255:0] dat_arr [0:15][0:1];
   logic         lru     [0:15];
   logic [3:0]   m_idx;
   logic         m_hit;
   logic         m_way;

   memtx_t       memtx_q [$];
   logic [31:0]  load_q  [$];

   dcache_controller_if bus();

   dcache_controller dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   task automatic chk_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] init_word(input int l, input int w);
      if (l == 'h21 && w == 0) return 32'hDEADBEEF;
      return 32'hC0DE_0000 | 32'(l * 32 + w * 4);
   endfunction

   function automatic logic [255:0] gold_line(input logic [31:0] a);
      logic [255:0] l;
      for (int w = 0; w < 8; w++) l[32*w +: 32] = gold[{a[12:5], 3'(w)}];
      return l;
   endfunction

   // SRAM model: hit way, or LRU victim on a miss
   always_comb begin
      m_idx = bus.sram_idx_o;
      m_hit = 1'b0;
      m_way = lru[m_idx];
      for (int w = 0; w < 2; w++) begin
         if (tag_arr[m_idx][w][24] && tag_arr[m_idx][w][22:0] == bus.cpu_addr_i[31:9]) begin
            m_hit = 1'b1;
            m_way = 1'(w);
         end
      end
      bus.sram_hit_i  = m_hit;
      bus.sram_tag_i  = tag_arr[m_idx][m_way];
      bus.sram_data_i = dat_arr[m_idx][m_way];
   end

   always @(posedge clk_i) begin
      if (sram_clr) begin
         for (int i = 0; i < 16; i++) begin
            lru[i] <= 1'b0;
            for (int w = 0; w < 2; w++) begin
               tag_arr[i][w] <= '0;
               dat_arr[i][w] <= '0;
            end
         end
      end else if (bus.sram_enable_o) begin
         if (bus.sram_write_o) begin
            tag_arr[m_idx][m_way] <= bus.sram_tag_o;
            dat_arr[m_idx][m_way] <= bus.sram_data_o;
            sram_wr_cnt           <= sram_wr_cnt + 1;
         end
         if (bus.sram_write_o || m_hit) lru[m_idx] <= ~m_way;
      end
   end

   // Off-chip memory: ack after mem_delay extra cycles, checked against scoreboard
   initial begin : mem_responder
      int     wait_cnt;
      int     en_cyc;
      memtx_t e;
      wait_cnt       = 0;
      en_cyc         = 0;
      bus.mem_ack_i  = 1'b0;
      bus.mem_data_i = '0;
      for (int l = 0; l < 256; l++)
         for (int w = 0; w < 8; w++) mem_arr[l][32*w +: 32] = init_word(l, w);
      forever begin
         @(negedge clk_i);
         if (rst_i) begin
            bus.mem_ack_i = 1'b0;
            wait_cnt      = 0;
            en_cyc        = 0;
         end else if (bus.mem_ack_i) begin
            bus.mem_ack_i = 1'b0;
         end else if (bus.mem_enable_o) begin
            en_cyc++;
            if (wait_cnt >= mem_delay) begin
               bus.mem_ack_i = 1'b1;
               tx_cnt++;
               chk_eq("mem_en_held_cycles", en_cyc, mem_delay + 1);
               if (bus.mem_write_o) mem_arr[bus.mem_addr_o[12:5]] = bus.mem_data_o;
               else                 bus.mem_data_i = mem_arr[bus.mem_addr_o[12:5]];
               chk_eq("memtx_expected", memtx_q.size() != 0, 1'b1);
               if (memtx_q.size() != 0) begin
                  e = memtx_q.pop_front();
                  chk_eq("memtx_write", bus.mem_write_o, e.wr);
                  chk_eq("memtx_addr", bus.mem_addr_o, e.addr);
                  if (e.wr) chk_eq("memtx_wb_line", bus.mem_data_o, e.data);
               end
               wait_cnt = 0;
               en_cyc   = 0;
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
            en_cyc   = 0;
         end
      end
   end

   task automatic cpu_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                             input int exp_tx, input int exp_fill, input string tag);
      int n;
      int fills;
      @(negedge clk_i);
      bus.cpu_addr_i     = addr;
      bus.cpu_data_i     = wdata;
      bus.cpu_MemRead_i  = ~wr;
      bus.cpu_MemWrite_i = wr;
      if (!wr) load_q.push_back(gold[addr[12:2]]);
      tx_cnt = 0;
      n      = 0;
      fills  = 0;
      #1;
      while (bus.cpu_stall_o && n < 300) begin
         if (bus.sram_write_o) begin
            fills++;
            chk_eq({tag, "_refill_tag"}, bus.sram_tag_o, {2'b10, addr[31:9]});
            chk_eq({tag, "_refill_line"}, bus.sram_data_o, gold_line(addr));
         end
         @(negedge clk_i);
         #1;
         n++;
      end
      chk_eq({tag, "_completes"}, n < 300, 1'b1);
      chk_eq({tag, "_stalled"}, n > 0, exp_fill > 0);
      chk_eq({tag, "_fills"}, fills, exp_fill);
      chk_eq({tag, "_sram_idx"}, bus.sram_idx_o, addr[8:5]);
      if (exp_fill == 0) chk_eq({tag, "_no_mem_req"}, bus.mem_enable_o, 1'b0);
      if (wr) begin
         gold[addr[12:2]] = wdata;
         chk_eq({tag, "_store_we"}, bus.sram_write_o, 1'b1);
         chk_eq({tag, "_store_tag"}, bus.sram_tag_o, {2'b11, addr[31:9]});
         chk_eq({tag, "_store_line"}, bus.sram_data_o, gold_line(addr));
         chk_eq({tag, "_store_rdata"}, bus.cpu_data_o, 32'h0);
      end else begin
         chk_eq({tag, "_load_we"}, bus.sram_write_o, 1'b0);
         chk_eq({tag, "_load_data"}, bus.cpu_data_o, load_q.pop_front());
      end
      @(negedge clk_i);
      bus.cpu_MemRead_i  = 1'b0;
      bus.cpu_MemWrite_i = 1'b0;
      #1;
      chk_eq({tag, "_mem_tx"}, tx_cnt, exp_tx);
      chk_eq({tag, "_idle_we"}, bus.sram_write_o, 1'b0);
      chk_eq({tag, "_idle_stall"}, bus.cpu_stall_o, 1'b0);
      chk_eq({tag, "_idle_rdata"}, bus.cpu_data_o, 32'h0);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int n;
      int snap;
      bus.cpu_addr_i     = '0;
      bus.cpu_data_i     = '0;
      bus.cpu_MemRead_i  = 1'b0;
      bus.cpu_MemWrite_i = 1'b0;
      for (int l = 0; l < 256; l++)
         for (int w = 0; w < 8; w++) gold[l*8 + w] = init_word(l, w);

      repeat (3) @(negedge clk_i);
      #1;
      chk_eq("rst_mem_enable", bus.mem_enable_o, 1'b0);
      chk_eq("rst_mem_write", bus.mem_write_o, 1'b0);
      chk_eq("rst_mem_addr", bus.mem_addr_o, 32'h0);
      chk_eq("rst_mem_data", bus.mem_data_o, 256'h0);
      chk_eq("rst_sram_write", bus.sram_write_o, 1'b0);
      chk_eq("rst_cpu_data", bus.cpu_data_o, 32'h0);
      chk_eq("rst_stall", bus.cpu_stall_o, 1'b0);
      @(negedge clk_i);
      rst_i    = 1'b0;
      sram_clr = 1'b0;

      // Cold load, 10-cycle memory
      mem_delay = 10;
      memtx_q.push_back({1'b0, 32'h0000_0420, 256'h0});
      cpu_access(1'b0, 32'h0000_0420, 32'h0, 1, 1, "t1_cold_load");
      // Repeat load hits
      cpu_access(1'b0, 32'h0000_0420, 32'h0, 0, 0, "t2_hit_load");
      // Store hit, word 3
      cpu_access(1'b1, 32'h0000_042C, 32'h1234_5678, 0, 0, "t3_store_hit");

      // Second way of set 1 (clean victim), then dirty write-back of tag 2
      mem_delay = 0;
      memtx_q.push_back({1'b0, 32'h0000_0620, 256'h0});
      cpu_access(1'b0, 32'h0000_0620, 32'h0, 1, 1, "t4_fill_way1");
      memtx_q.push_back({1'b1, 32'h0000_0420, gold_line(32'h0000_0420)});
      memtx_q.push_back({1'b0, 32'h0000_0820, 256'h0});
      cpu_access(1'b0, 32'h0000_0820, 32'h0, 2, 1, "t4_wb_miss");
      cpu_access(1'b0, 32'h0000_0824, 32'h0, 0, 0, "t4_after_hit");

      // Ack delays 0, 1, 50
      memtx_q.push_back({1'b0, 32'h0000_0040, 256'h0});
      cpu_access(1'b0, 32'h0000_0044, 32'h0, 1, 1, "t5_delay0");
      mem_delay = 1;
      memtx_q.push_back({1'b0, 32'h0000_0060, 256'h0});
      cpu_access(1'b0, 32'h0000_0078, 32'h0, 1, 1, "t5_delay1");
      mem_delay = 50;
      memtx_q.push_back({1'b0, 32'h0000_0080, 256'h0});
      cpu_access(1'b1, 32'h0000_0090, 32'hA5A5_0F0F, 1, 1, "t5_delay50_store");

      // Make tag-3 way dirty and LRU, then reset in the middle of its write-back
      cpu_access(1'b1, 32'h0000_0624, 32'hCAFE_F00D, 0, 0, "t6_dirty_way1");
      cpu_access(1'b0, 32'h0000_0820, 32'h0, 0, 0, "t6_touch_way0");
      @(negedge clk_i);
      bus.cpu_addr_i    = 32'h0000_0A20;
      bus.cpu_MemRead_i = 1'b1;
      #1;
      n = 0;
      while (!(bus.mem_enable_o && bus.mem_write_o) && n < 20) begin
         @(negedge clk_i);
         #1;
         n++;
      end
      chk_eq("t6_reached_wb", n < 20, 1'b1);
      chk_eq("t6_wb_addr", bus.mem_addr_o, 32'h0000_0620);
      snap  = sram_wr_cnt;
      rst_i = 1'b1;
      #1;
      chk_eq("t6_rst_mem_enable", bus.mem_enable_o, 1'b0);
      chk_eq("t6_rst_mem_write", bus.mem_write_o, 1'b0);
      chk_eq("t6_rst_sram_write", bus.sram_write_o, 1'b0);
      chk_eq("t6_rst_stall_vs_hit", bus.cpu_stall_o, !bus.sram_hit_i);
      chk_eq("t6_rst_stall", bus.cpu_stall_o, 1'b1);
      @(negedge clk_i);
      #1;
      chk_eq("t6_rst_hold_mem_enable", bus.mem_enable_o, 1'b0);
      bus.cpu_MemRead_i = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b0;
      #1;
      chk_eq("t6_no_sram_write", sram_wr_cnt, snap);
      chk_eq("t6_idle_stall", bus.cpu_stall_o, 1'b0);

      // Same miss again completes normally after the abort
      mem_delay = 1;
      memtx_q.push_back({1'b1, 32'h0000_0620, gold_line(32'h0000_0620)});
      memtx_q.push_back({1'b0, 32'h0000_0A20, 256'h0});
      cpu_access(1'b0, 32'h0000_0A20, 32'h0, 2, 1, "t6_retry");

      chk_eq("load_q_drained", load_q.size(), 0);
      chk_eq("memtx_q_drained", memtx_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Data-cache controller between the CPU MEM stage and the 2-way dcache_sram (16 sets, 256-bit lines, 25-bit tag entries {valid, dirty, tag[22:0]}) and the off-chip data memory.
- Splits CPU addresses, merges 32-bit writes into lines, and stalls the pipeline on a miss.
- On a miss it writes back a dirty victim and refills the line through a 5-state FSM.

Parameters:
- TAG_W, 23, address tag width (addr[31:9])
- IDX_W, 4, set index width (addr[8:5])
- OFF_W, 5, byte offset width (addr[4:0]); word select = addr[4:2]
- LINE_W, 256, cache line width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- cpu_addr_i  in  32  byte address
- cpu_data_i  in  32  store data
- cpu_MemRead_i  in  1  load request
- cpu_MemWrite_i  in  1  store request
- cpu_data_o  out  32  load data
- cpu_stall_o  out  1  pipeline stall
- mem_data_i  in  256  refill line
- mem_ack_i  in  1  one-cycle completion pulse
- mem_data_o  out  256  write-back line
- mem_addr_o  out  32  line address, low 5 bits are 0
- mem_enable_o  out  1  memory request
- mem_write_o  out  1  1 = write-back, 0 = refill
- sram_idx_o  out  4  set index
- sram_tag_o  out  25  {valid, dirty, tag}
- sram_data_o  out  256  line to SRAM
- sram_enable_o  out  1  SRAM access
- sram_write_o  out  1  SRAM write
- sram_tag_i  in  25  hit way tag; on miss, the LRU victim tag
- sram_data_i  in  256  hit way line; on miss, the LRU victim line
- sram_hit_i  in  1  hit

Behaviour:
- req = cpu_MemRead_i | cpu_MemWrite_i.
- sram_idx_o = addr[8:5] at all times.
- sram_enable_o = req, or state is READMISSOK.
- cpu_stall_o = req & ~sram_hit_i, combinational; held through the whole miss sequence.
- Load hit: cpu_data_o = sram_data_i word addr[4:2] (bits [32w+31:32w]), same cycle, no stall. Otherwise cpu_data_o = 0.
- Store hit: sram_write_o = 1; sram_data_o = sram_data_i with word addr[4:2] replaced by cpu_data_i; sram_tag_o = {1,1,addr[31:9]}. Completes in one cycle with no stall.
- FSM states: IDLE, MISS, WRITEBACK, READMISS, READMISSOK. Reset state is IDLE.
- IDLE -> MISS on req & ~sram_hit_i. At this transition, latch victim_tag <= sram_tag_i and victim_line <= sram_data_i.
- MISS -> WRITEBACK if victim_tag[24] & victim_tag[23] (valid and dirty); otherwise MISS -> READMISS.
- WRITEBACK:
  - mem_enable_o = 1, mem_write_o = 1.
  - mem_addr_o = {victim_tag[22:0], idx, 5'b0}; mem_data_o = victim_line.
  - -> READMISS on mem_ack_i.
- READMISS:
  - mem_enable_o = 1, mem_write_o = 0.
  - mem_addr_o = {addr[31:9], idx, 5'b0}.
  - On mem_ack_i: latch refill <= mem_data_i, then -> READMISSOK.
- READMISSOK (exactly one cycle):
  - sram_write_o = 1, sram_tag_o = {1,0,addr[31:9]}, sram_data_o = refill.
  - -> IDLE.
  - The next cycle the request re-accesses and hits; a store merges then, so a store miss ends dirty.
- mem_enable_o is held high until mem_ack_i is sampled, then drops in the next state. Memory latency is unbounded.
- mem_ack_i is ignored outside WRITEBACK and READMISS.
- The CPU holds addr, data and request stable while stalled.
- Reset values: state IDLE; victim and refill registers 0; all mem_*, sram_write_o and cpu_data_o are 0.
- Reset mid-operation: abort immediately and return to IDLE. The memory sees mem_enable_o drop; the line is not written to the SRAM.
- Read and write asserted together: treat as a store.
- No request: FSM stays in IDLE, all write strobes are 0.

Decomposition:
- Package dcache_pkg holds:
  - state enum (IDLE=0, MISS=1, WRITEBACK=2, READMISS=3, READMISSOK=4)
  - TAG_W, IDX_W, OFF_W, LINE_W
  - tag-field bit positions (VALID=24, DIRTY=23)
- One natural sub-module: dcache_word_merge. Combinational; selects or replaces a 32-bit word in a 256-bit line by addr[4:2]. Used for both the load mux and the store merge.

Test Plan:
1. Cold load at 0x0000_0420 (idx 1, tag 2); memory returns line with word0 = 0xDEADBEEF after 10 cycles. Required: stall high; READMISS with mem_addr_o = 0x420, no WRITEBACK; READMISSOK writes tag 0x1000002. The following cycle cpu_data_o = 0xDEADBEEF and stall drops.
2. Repeat load at 0x0000_0420. Required: hit, no stall, cpu_data_o = 0xDEADBEEF, mem_enable_o stays 0.
3. Store 0x12345678 to 0x0000_042C. Required: single cycle; sram_write_o = 1; word 3 of the line is 0x12345678; sram_tag_o = 0x1800002.
4. Fill both ways of set 1 with tags 2 and 3, leaving the tag-2 way dirty and LRU, then load tag 4 at 0x0000_0820. Required: WRITEBACK to 0x420 with the dirty line, then READMISS at 0x820, then hit.
5. Delay mem_ack_i by 0, 1 and 50 cycles. Required: mem_enable_o held until the ack; exactly one memory transaction per state.
6. Assert rst_i during WRITEBACK. Required: FSM in IDLE and mem_enable_o = 0 in the same cycle, cpu_stall_o follows sram_hit_i, no SRAM write.
